seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Controller for a programmable serial pattern detector on a 1-bit stream x.
//  Holds the configuration: pattern, length, overlap mode, match target and timeout.
//  Sequences each detection run (IDLE/RUN/DONE) and counts matches.
//  Reports completion to the host through done/timed_out.
// PARAMETERS
//  MAX_LEN  8   maximum pattern length in bits
//  LEN_W    4   width of cfg_len; must hold MAX_LEN
//  CNT_W    8   width of cfg_target and match_cnt
//  TO_W     16  width of cfg_timeout and the idle-cycle timer
// PORTS
//  clk          in   1        clock; all state changes on the rising edge
//  rst          in   1        asynchronous, active-low reset
//  cfg_valid    in   1        configuration offer
//  cfg_ready    out  1        configuration accepted when cfg_valid & cfg_ready
//  cfg_pattern  in   MAX_LEN  pattern; bit0 = newest bit, bit(len-1) = oldest bit
//  cfg_len      in   LEN_W    pattern length; 0 = invalid; >MAX_LEN saturates to MAX_LEN
//  cfg_overlap  in   1        1 = overlapping matches allowed
//  cfg_target   in   CNT_W    number of matches that ends the run; 0 = never ends on count
//  cfg_timeout  in   TO_W     clocks without a match that end the run; 0 = disabled
//  start        in   1        begin a run
//  abort        in   1        cancel; go to IDLE
//  x_valid      in   1        x is sampled this edge
//  x            in   1        serial data bit
//  z            out  1        1-cycle pulse per match
//  match_cnt    out  CNT_W    matches in the current/last run; saturates at all-ones
//  busy         out  1        high in RUN
//  done         out  1        high while in DONE
//  timed_out    out  1        high while in DONE when the run ended by timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; config registers cleared; history and fill counter cleared.
//   Outputs on reset: z=0, match_cnt=0, busy=0, done=0, timed_out=0, cfg_ready=1.
//  cfg_ready=1 in IDLE and DONE, 0 in RUN; cfg_valid is ignored in RUN.
//  IDLE->RUN on start when the effective len != 0.
//   Same-cycle cfg handshake + start: the new config is used for the run.
//   Start with len 0 is ignored; state stays IDLE.
//  DONE->RUN on start, using the held config; DONE->IDLE on abort.
//  Run entry clears: history shift reg, fill counter, match_cnt, timer, timed_out.
//  RUN, per edge with x_valid=1:
//   - history <= {history, x}; fill counter increments, saturating at MAX_LEN.
//   - Match when fill >= len AND history_next[len-1:0] == cfg_pattern[len-1:0].
//  On match:
//   - z=1 for the single cycle after the sampling edge (registered).
//   - match_cnt increments on the same edge.
//   - Timer cleared.
//   - If cfg_overlap=0, the fill counter resets to 0: the next match needs len fresh bits.
//  x_valid=0: history and fill are held; the timer still counts.
//  Timer counts every clock in RUN. Reaching cfg_timeout (nonzero) -> DONE with timed_out=1.
//  Match count reaching nonzero cfg_target -> DONE with timed_out=0.
//   done rises on the same edge as the final z.
//  Priority: abort > match > timeout.
//   A match on the timeout edge counts and clears the timer; no timeout occurs that edge.
//  abort in any state -> IDLE next edge; z=0; match_cnt holds its value; done and timed_out clear.
//  DONE holds match_cnt, done and timed_out until start or abort.
//  x and x_valid are ignored outside RUN.
// TESTING
//  1. Reset mid-RUN (rst low between edges) -> all outputs at reset values immediately; state IDLE.
//  2. pattern=4'b1101, len=4, overlap=1, target=0, timeout=0.
//     Stream 0,0,1,1,0,1,1,0,1,0,1,1,0, one bit per clock.
//     -> z after bits 5 and 8 (0-based); match_cnt=2.
//  3. Same stream with overlap=0 -> single z after bit 5; match_cnt=1.
//  4. Config as test 2 with target=2 -> done and busy=0 on the edge of the 2nd z; timed_out=0.
//     cfg_ready returns to 1.
//  5. timeout=5, stream all zeros -> done=1, timed_out=1 on the 5th clock after start; match_cnt=0.
//  6. Edge cases:
//     - abort during RUN -> IDLE next edge.
//     - start with len=0 -> stays IDLE.
//     - cfg_valid during RUN -> cfg_ready=0; config unchanged.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector controller
// Holds run configuration, sequences IDLE/RUN/DONE and counts pattern matches on x.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               x_valid,
    input  logic               x,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               timed_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;
    logic [TO_W-1:0]    timeout_q;

    logic [MAX_LEN-1:0] hist_q, hist_next, mask;
    logic [LEN_W-1:0]   fill_q, fill_inc;
    logic [TO_W-1:0]    timer_q, timer_inc;
    logic [CNT_W-1:0]   cnt_inc;

    logic               cfg_fire, run_entry, match, hit_target, hit_timeout;
    logic [LEN_W-1:0]   cfg_len_sat, start_len;

    // A start in the same cycle as a config handshake runs with the new length.
    assign cfg_fire    = cfg_valid & cfg_ready;
    assign cfg_len_sat = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    assign start_len   = cfg_fire ? cfg_len_sat : len_q;
    assign run_entry   = (state != RUN) && (state_next == RUN);

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        hist_next   = (hist_q << 1) | MAX_LEN'(x);
        fill_inc    = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        cnt_inc     = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
        timer_inc   = timer_q + 1'b1;
        match       = (state == RUN) && x_valid && (fill_inc >= len_q) &&
                      (((hist_next ^ pat_q) & mask) == '0);
        hit_target  = match && (target_q != '0) && (cnt_inc == target_q);
        // A match on the timeout edge restarts the timer instead of ending the run.
        hit_timeout = (state == RUN) && !match && (timeout_q != '0) &&
                      (timer_inc == timeout_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start && (start_len != '0)) state_next = RUN;
                RUN:        if (hit_target || hit_timeout) state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        cfg_ready = (state != RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q     <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            timeout_q <= '0;
        end else if (cfg_fire) begin
            pat_q     <= cfg_pattern;
            len_q     <= cfg_len_sat;
            overlap_q <= cfg_overlap;
            target_q  <= cfg_target;
            timeout_q <= cfg_timeout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            timer_q   <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
            timed_out <= 1'b0;
        end else if (abort) begin
            z         <= 1'b0;
            timed_out <= 1'b0;
        end else if (run_entry) begin
            hist_q    <= '0;
            fill_q    <= '0;
            timer_q   <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
            timed_out <= 1'b0;
        end else if (state == RUN) begin
            z       <= match;
            timer_q <= match ? '0 : timer_inc;
            if (x_valid) begin
                hist_q <= hist_next;
                fill_q <= (match && !overlap_q) ? '0 : fill_inc;
            end
            if (match) match_cnt <= cnt_inc;
            if (hit_timeout) timed_out <= 1'b1;
        end else begin
            z <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - scoreboard bench for seq_detect_ctrl
// Stimulus pushes expected z/done events; a negedge monitor pops and compares them.
module tb_seq_detect_ctrl;

    logic        clk, rst;
    logic        cfg_valid, cfg_ready, cfg_overlap;
    logic [7:0]  cfg_pattern, cfg_target;
    logic [3:0]  cfg_len;
    logic [15:0] cfg_timeout;
    logic        start, abort, x_valid, x;
    logic        z, busy, done, timed_out;
    logic [7:0]  match_cnt;

    seq_detect_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
        .start(start), .abort(abort), .x_valid(x_valid), .x(x),
        .z(z), .match_cnt(match_cnt), .busy(busy), .done(done), .timed_out(timed_out)
    );

    typedef struct {
        logic z;
        int   cnt;
        logic done;
        logic to;
        logic busy;
    } ev_t;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic done_prev = 1'b0;
    logic s_bits[13] = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic ez, input int ec, input logic ed, input logic et, input logic eb);
        ev_t e;
        e.z = ez; e.cnt = ec; e.done = ed; e.to = et; e.busy = eb;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o,
                             input logic [7:0] t, input logic [15:0] to);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_timeout = to;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic start_run;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        x_valid = 1'b1;
        x = b;
        tick();
        x_valid = 1'b0;
    endtask

    task automatic do_abort;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Monitor: each z pulse or rising done is one DUT event to be matched.
    always @(negedge clk) begin
        if (rst && (z || (done && !done_prev))) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got z=%0d done=%0d cnt=%0d expected no event", z, done, match_cnt);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("sb_z", z, e.z);
                check("sb_cnt", match_cnt, e.cnt);
                check("sb_done", done, e.done);
                check("sb_timed_out", timed_out, e.to);
                check("sb_busy", busy, e.busy);
            end
        end
        done_prev = done;
    end

    initial begin
        rst = 1'b0;
        cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        cfg_target = 0; cfg_timeout = 0; start = 0; abort = 0; x_valid = 0; x = 0;
        #12;
        check("rst_z", z, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b1;
        tick();

        // Overlapping matches on the reference stream
        configure(8'b1101, 4'd4, 1'b1, 8'd0, 16'd0);
        start_run();
        check("t2_busy", busy, 1);
        check("t2_cfg_ready", cfg_ready, 0);
        for (int i = 0; i < 13; i++) begin
            if (i == 5) push(1, 1, 0, 0, 1);
            if (i == 8) push(1, 2, 0, 0, 1);
            send_bit(s_bits[i]);
        end
        tick();
        check("t2_cnt", match_cnt, 2);
        check("t2_still_busy", busy, 1);
        do_abort();
        check("t2_abort_busy", busy, 0);
        check("t2_abort_done", done, 0);
        check("t2_abort_cfg_ready", cfg_ready, 1);
        check("t2_abort_cnt_held", match_cnt, 2);

        // Non-overlapping
        configure(8'b1101, 4'd4, 1'b0, 8'd0, 16'd0);
        start_run();
        for (int i = 0; i < 13; i++) begin
            if (i == 5) push(1, 1, 0, 0, 1);
            send_bit(s_bits[i]);
        end
        tick();
        check("t3_cnt", match_cnt, 1);
        do_abort();

        // Target of 2 ends the run on the second z
        configure(8'b1101, 4'd4, 1'b1, 8'd2, 16'd0);
        start_run();
        for (int i = 0; i < 13; i++) begin
            if (i == 5) push(1, 1, 0, 0, 1);
            if (i == 8) push(1, 2, 1, 0, 0);
            send_bit(s_bits[i]);
        end
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_timed_out", timed_out, 0);
        check("t4_cfg_ready", cfg_ready, 1);
        check("t4_cnt_held", match_cnt, 2);
        do_abort();
        check("t4_abort_done", done, 0);

        // Timeout of 5 on an all-zero stream
        configure(8'b1101, 4'd4, 1'b1, 8'd0, 16'd5);
        start_run();
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) push(0, 0, 1, 1, 0);
            send_bit(1'b0);
            if (i == 4) check("t5_not_yet_done", done, 0);
        end
        check("t5_done", done, 1);
        check("t5_timed_out", timed_out, 1);
        check("t5_cnt", match_cnt, 0);
        start_run();
        check("t5_restart_busy", busy, 1);
        check("t5_restart_timed_out", timed_out, 0);
        check("t5_restart_done", done, 0);
        do_abort();

        // Match on the timeout edge counts and restarts the timer
        configure(8'b1, 4'd1, 1'b1, 8'd0, 16'd3);
        start_run();
        for (int i = 0; i < 6; i++) begin
            if (i == 2) push(1, 1, 0, 0, 1);
            if (i == 5) push(0, 1, 1, 1, 0);
            send_bit(i == 2);
        end
        check("to_match_done", done, 1);
        do_abort();

        // Length above MAX_LEN saturates to 8; target 1
        configure(8'hA5, 4'd15, 1'b1, 8'd1, 16'd0);
        start_run();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] pv;
            pv = 8'hA5;
            if (i == 0) push(1, 1, 1, 0, 0);
            send_bit(pv[i]);
        end
        check("sat_done", done, 1);
        do_abort();

        // Start with length 0 is ignored
        configure(8'b1101, 4'd0, 1'b1, 8'd0, 16'd0);
        start_run();
        check("len0_busy", busy, 0);
        check("len0_cfg_ready", cfg_ready, 1);

        // Config offered during RUN is refused and does not alter the run
        configure(8'b1101, 4'd4, 1'b1, 8'd0, 16'd0);
        start_run();
        cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_valid = 1'b1;
        #1;
        check("run_cfg_ready", cfg_ready, 0);
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) push(1, 1, 0, 0, 1);
            if (i == 8) push(1, 2, 0, 0, 1);
            send_bit(s_bits[i]);
        end
        tick();
        check("run_cfg_cnt", match_cnt, 2);
        do_abort();

        // Asynchronous reset in the middle of a run
        configure(8'b1101, 4'd4, 1'b1, 8'd0, 16'd0);
        start_run();
        for (int i = 0; i < 7; i++) begin
            if (i == 5) push(1, 1, 0, 0, 1);
            send_bit(s_bits[i]);
        end
        check("mid_cnt_before", match_cnt, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", match_cnt, 0);
        check("mid_rst_z", z, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cfg_ready", cfg_ready, 1);
        tick();
        rst = 1'b1;
        tick();
        start_run();
        check("rst_cfg_cleared", busy, 0);

        tick();
        tick();
        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
